fft_input_buffer: RTL and testbench



---
 rtl/fft_input_buffer_pkg.sv | 29 ++
 rtl/fft_input_buffer_if.sv | 33 +++
 rtl/fft_input_buffer_ram.sv | 38 +++
 rtl/fft_input_buffer.sv | 91 +++++++++
 tb/tb_fft_input_buffer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_pkg
// Purpose  : Frame geometry, buffer state encoding and bit-reversal helper.
// Revision : 1.0
// ============================================================================
package fft_pkg;

  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    READY = 1'b1
  } buf_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : fft_input_buffer_if
// Purpose   : Sample-in handshake plus FFT-stage read port of the input buffer.
// Revision  : 1.0
// ============================================================================
interface fft_input_buffer_if #(
  parameter int LOG2N = fft_pkg::LOG2N,
  parameter int IN_W  = fft_pkg::IN_W,
  parameter int OUT_W = fft_pkg::OUT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              frame_ready;
  logic [LOG2N-1:0]  rd_addr;
  logic [OUT_W-1:0]  rd_data;
  logic              frame_release;
  logic [LOG2N:0]    fill_count;

  modport master (
    output in_valid, in_data, rd_addr, frame_release,
    input  in_ready, frame_ready, rd_data, fill_count
  );

  modport slave (
    input  in_valid, in_data, rd_addr, frame_release,
    output in_ready, frame_ready, rd_data, fill_count
  );

endinterface
`default_nettype wire

// File: rtl/fft_input_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_sample_ram
// Purpose  : Simple dual-port RAM, synchronous write, registered read.
// Revision : 1.0
// ============================================================================
module fft_sample_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately left uninitialised by reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_buffer
// Purpose  : Stores one frame of samples at bit-reversed addresses and serves
//            it to the FFT stage until released.
// Options  : FFT_INBUF_SIGN_EXT_EN - sign-extend read data instead of zero-pad.
// Revision : 1.0
// ============================================================================
module fft_input_buffer
  import fft_pkg::*;
(
  input wire logic          clk,
  input wire logic          rst_n,
  fft_input_buffer_if.slave bus
);

  buf_state_t        state;
  buf_state_t        state_nxt;
  logic [LOG2N-1:0]  wr_ptr;
  logic [LOG2N:0]    count;
  logic [IN_W-1:0]   ram_q;
  logic [OUT_W-IN_W-1:0] upper;
  logic              xfer;
  logic              release_ok;

  // Derived from state directly so the handshake has no combinational loop.
  assign xfer       = bus.in_valid && (state == FILL);
  assign release_ok = bus.frame_release && (state == READY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (release_ok) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.in_ready    = 1'b0;
    bus.frame_ready = 1'b0;
    case (state)
      FILL: begin
        bus.in_ready = 1'b1;
        if (xfer && (wr_ptr == LOG2N'(N - 1))) begin
          state_nxt = READY;
        end
      end
      READY: begin
        bus.frame_ready = 1'b1;
        if (bus.frame_release) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  fft_sample_ram #(
    .ADDR_W (LOG2N),
    .DATA_W (IN_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (xfer),
    .waddr (bitrev(wr_ptr)),
    .wdata (bus.in_data),
    .raddr (bus.rd_addr),
    .rdata (ram_q)
  );

`ifdef FFT_INBUF_SIGN_EXT_EN
  assign upper = {(OUT_W-IN_W){ram_q[IN_W-1]}};
`else
  assign upper = '0;
`endif

  assign bus.rd_data    = {upper, ram_q};
  assign bus.fill_count = count;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_buffer
// Purpose  : Directed scoreboard bench for fft_input_buffer.
// Revision : 1.0
// ============================================================================
module tb_fft_input_buffer;

  logic clk;
  logic rst_n;

  fft_input_buffer_if bus_if ();

  fft_input_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q  [$];
  string       name_q [$];
  logic        rd_req;
  logic        rd_req_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_req_q <= rd_req;

  // Scoreboard monitor: one expected word per issued read, checked a cycle later.
  always @(negedge clk) begin
    if (rd_req_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %h with no expected entry", bus_if.rd_data);
      end else begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus_if.rd_data !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, bus_if.rd_data, e);
        end
      end
    end
  end

  function automatic logic [15:0] ext(input logic [7:0] v);
`ifdef FFT_INBUF_SIGN_EXT_EN
    return {{8{v[7]}}, v};
`else
    return {8'h00, v};
`endif
  endfunction

  task automatic cmp(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic status(input string n, input int ir, input int fr, input int fc);
    @(negedge clk);
    cmp({n, "_in_ready"},    int'(bus_if.in_ready),    ir);
    cmp({n, "_frame_ready"}, int'(bus_if.frame_ready), fr);
    cmp({n, "_fill_count"},  int'(bus_if.fill_count),  fc);
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string n);
    bus_if.rd_addr = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic release_pulse();
    bus_if.frame_release = 1'b1;
    @(posedge clk);
    #1;
    bus_if.frame_release = 1'b0;
  endtask

  logic [7:0] sine [16] = '{8'h00, 8'h30, 8'h59, 8'h75, 8'h7F, 8'h75, 8'h59, 8'h30,
                            8'h00, 8'hD0, 8'hA7, 8'h8B, 8'h81, 8'h8B, 8'hA7, 8'hD0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n                = 1'b0;
    rd_req               = 1'b0;
    bus_if.in_valid      = 1'b0;
    bus_if.in_data       = '0;
    bus_if.rd_addr       = '0;
    bus_if.frame_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    status("reset", 1, 0, 0);
    cmp("reset_rd_data", int'(bus_if.rd_data), 0);

    // Sine frame, continuous stream.
    for (int k = 0; k < 15; k++) push(sine[k]);
    status("sine_15", 1, 0, 15);
    push(sine[15]);
    status("sine_full", 0, 1, 16);
    rd(4'd8,  16'h0030, "sine_addr8");
    rd(4'd4,  16'h0059, "sine_addr4");
    rd(4'd2,  16'h007F, "sine_addr2");
    rd(4'd9,  ext(8'hD0), "sine_addr9_ext");
    rd(4'd15, ext(8'hD0), "sine_addr15_ext");
    rd(4'd12, 16'h0075, "sine_addr12");
    rd(4'd3,  ext(8'h81), "sine_addr3_ext");

    // Back-pressure while the frame is held.
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h11;
    repeat (3) @(posedge clk);
    status("backpressure", 0, 1, 16);
    rd(4'd0, 16'h0000, "backpressure_addr0");
    release_pulse();
    status("after_release", 1, 0, 0);
    bus_if.in_valid = 1'b0;

    // Release during FILL is ignored.
    for (int k = 0; k < 5; k++) push(8'(8'h10 + k));
    status("fill5", 1, 0, 5);
    release_pulse();
    status("fill5_release_ignored", 1, 0, 5);
    for (int k = 5; k < 15; k++) push(8'(8'h10 + k));
    status("fill15", 1, 0, 15);
    push(8'h1F);
    status("frame2_full", 0, 1, 16);
    rd(4'd8,  16'h0011, "frame2_addr8");
    rd(4'd15, 16'h001F, "frame2_addr15");
    rd(4'd3,  16'h001C, "frame2_addr3");
    release_pulse();
    status("frame2_released", 1, 0, 0);

    // Gapped source.
    for (int k = 0; k < 16; k++) begin
      push(8'(8'h80 | k));
      @(posedge clk);
      #1;
      if (k == 7) status("gap_8", 1, 0, 8);
    end
    status("gap_full", 0, 1, 16);
    rd(4'd6, ext(8'h86), "gap_addr6");
    rd(4'd9, ext(8'h89), "gap_addr9");
    rd(4'd0, ext(8'h80), "gap_addr0");
    release_pulse();

    // Reset mid-fill, then a fresh frame.
    for (int k = 0; k < 7; k++) push(8'(8'h20 + k));
    status("fill7", 1, 0, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    status("midfill_reset", 1, 0, 0);
    cmp("midfill_reset_rd_data", int'(bus_if.rd_data), 0);
    for (int k = 0; k < 16; k++) push(8'(8'h40 + k));
    status("frame4_full", 0, 1, 16);
    rd(4'd1, 16'h0048, "frame4_addr1");
    rd(4'd0, 16'h0040, "frame4_addr0");

    // Reset while READY.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    status("ready_reset", 1, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
